// File: rtl/mdio_master.sv
// MDIO/MDC management-frame master for Clause 22 and Clause 45 PHY access.
// Builds MDC from clk and handles the read turnaround on the serial input.
module mdio_master #(
    parameter int CLK_DIV      = 4,
    parameter int PREAMBLE_LEN = 32,
    parameter bit C45_EN       = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [1:0]  op,
    input  logic [4:0]  phy_addr,
    input  logic [4:0]  reg_addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        done,
    output logic        rd_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_out,
    output logic        mdio_oe,
    input  logic        mdio_in
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE
    } state_t;

    localparam logic [8:0] RISE     = 9'(CLK_DIV - 1);
    localparam logic [8:0] PEND     = 9'(2 * CLK_DIV - 1);
    localparam logic [5:0] PRE_LAST =
        6'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);

    state_t      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [5:0]  bits_q, bits_d;
    logic [31:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic        ta_err_q, ta_err_d;
    logic        is_read_q, is_read_d;
    logic        mdc_q, mdc_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        rd_err_q, rd_err_d;

    logic in_frame;
    logic rise;
    logic per_end;
    logic last_bit;
    logic eff_mode;

    assign in_frame = (state_q == S_PRE) || (state_q == S_HDR) ||
                      (state_q == S_TA)  || (state_q == S_DATA);
    assign rise     = in_frame && (cnt_q == RISE);
    assign per_end  = in_frame && (cnt_q == PEND);
    assign eff_mode = mode & C45_EN;

    always_comb begin
        last_bit = 1'b0;
        unique case (state_q)
            S_PRE:   last_bit = (bits_q == PRE_LAST);
            S_HDR:   last_bit = (bits_q == 6'd13);
            S_TA:    last_bit = (bits_q == 6'd1);
            S_DATA:  last_bit = (bits_q == 6'd15);
            default: last_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (PREAMBLE_LEN > 0) ? S_PRE : S_HDR;
                end
            end
            S_PRE:   if (per_end && last_bit) state_d = S_HDR;
            S_HDR:   if (per_end && last_bit) state_d = S_TA;
            S_TA:    if (per_end && last_bit) state_d = S_DATA;
            S_DATA:  if (per_end && last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = in_frame;
        done     = (state_q == S_DONE);
        mdio_oe  = 1'b0;
        mdio_out = 1'b0;
        unique case (state_q)
            S_PRE: begin
                mdio_oe  = 1'b1;
                mdio_out = 1'b1;
            end
            S_HDR: begin
                mdio_oe  = 1'b1;
                mdio_out = tx_q[31];
            end
            S_TA, S_DATA: begin
                mdio_oe  = ~is_read_q;
                mdio_out = tx_q[31] & ~is_read_q;
            end
            default: begin
                mdio_oe  = 1'b0;
                mdio_out = 1'b0;
            end
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        bits_d    = bits_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        ta_err_d  = ta_err_q;
        is_read_d = is_read_q;
        mdc_d     = mdc_q;
        rd_data_d = rd_data_q;
        rd_err_d  = rd_err_q;
        if (state_q == S_IDLE && start) begin
            is_read_d = eff_mode ? op[1] : (op == 2'b10);
            tx_d      = {(eff_mode ? 2'b00 : 2'b01), op, phy_addr,
                         reg_addr, 2'b10, wr_data};
            cnt_d     = '0;
            bits_d    = '0;
            rx_d      = '0;
            ta_err_d  = 1'b0;
            mdc_d     = 1'b0;
        end else if (in_frame) begin
            if (rise) begin
                mdc_d = 1'b1;
                if (state_q == S_TA && bits_q == 6'd1) begin
                    ta_err_d = mdio_in;
                end
                if (state_q == S_DATA) begin
                    rx_d = {rx_q[14:0], mdio_in};
                end
            end
            if (per_end) begin
                cnt_d  = '0;
                mdc_d  = 1'b0;
                bits_d = last_bit ? 6'd0 : bits_q + 6'd1;
                // preamble is constant ones, so tx only advances after it
                if (state_q != S_PRE) begin
                    tx_d = {tx_q[30:0], 1'b0};
                end
                if (state_q == S_DATA && last_bit) begin
                    rd_data_d = is_read_q ? rx_q : rd_data_q;
                    rd_err_d  = is_read_q & ta_err_q;
                end
            end else begin
                cnt_d = cnt_q + 9'd1;
            end
        end else begin
            cnt_d = '0;
            mdc_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            bits_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            ta_err_q  <= 1'b0;
            is_read_q <= 1'b0;
            mdc_q     <= 1'b0;
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bits_q    <= bits_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            ta_err_q  <= ta_err_d;
            is_read_q <= is_read_d;
            mdc_q     <= mdc_d;
            rd_data_q <= rd_data_d;
            rd_err_q  <= rd_err_d;
        end
    end

    assign mdc     = mdc_q;
    assign rd_data = rd_data_q;
    assign rd_err  = rd_err_q;

endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- Parametrised MDIO/MDC management-frame master; successor to the fixed single-mode frame generator.
- Serialises IEEE 802.3 Clause 22 and, optionally, Clause 45 management frames to an external PHY.
- Generates MDC from clk with a configurable divider and a configurable preamble length.
- Handles the read turnaround with a 1-bit serial MDIO input and reports the result with a done/error handshake.
- Sits between the register/control interface and the top-level MDIO tristate pad.

Parameters:
- CLK_DIV, 4: MDC half-period in clk cycles; legal range 2..255.
- PREAMBLE_LEN, 32: number of preamble '1' bits; legal range 0..32.
- C45_EN, 1: 1 enables Clause 45 frames; 0 forces Clause 22 and ignores mode.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  frame request; sampled only in IDLE
- mode  in  1  0 = Clause 22, 1 = Clause 45
- op  in  2  opcode. C22: 01 write, 10 read. C45: 00 address, 01 write, 11 read, 10 post-read-increment read
- phy_addr  in  5  PHYAD / PRTAD
- reg_addr  in  5  REGAD (C22) or DEVAD (C45)
- wr_data  in  16  write data, or the address for a C45 address frame
- rd_data  out  16  read result
- done  out  1  one-cycle pulse at end of frame
- rd_err  out  1  valid with done; turnaround error
- busy  out  1  frame in progress
- mdc  out  1  management clock
- mdio_out  out  1  serial data to pad
- mdio_oe  out  1  pad output enable
- mdio_in  in  1  serial data from pad

Behaviour:
- Reset state:
  - rd_data = 0, done = 0, rd_err = 0, busy = 0, mdc = 0, mdio_out = 0, mdio_oe = 0, FSM = IDLE.
  - rst mid-frame aborts the frame immediately: no done pulse, and rd_data is cleared to 0.
- Accept: in IDLE with start = 1 at edge E, latch mode/op/phy_addr/reg_addr/wr_data. busy = 1 from E+1.
- Ignored requests: start while busy is ignored, and latched fields do not change.
- Frame type:
  - is_read = (eff_mode == 0) ? (op == 10) : op[1], where eff_mode = mode & C45_EN.
  - ST = 01 for C22, 00 for C45.
- Bit timing:
  - Each bit period is 2*CLK_DIV cycles.
  - First CLK_DIV cycles: mdc = 0. Remaining CLK_DIV cycles: mdc = 1.
  - mdio_out and mdio_oe update on the first cycle of each period (the MDC falling point).
  - mdio_in is sampled on the clk edge where mdc goes 0 to 1.
- Frame layout, MSB first: PREAMBLE_LEN ones, ST[1:0], OP[1:0], PHYAD[4:0], REGAD/DEVAD[4:0], TA[1:0], DATA[15:0]. Total bit periods N = PREAMBLE_LEN + 32.
- FSM: IDLE -> PRE (skipped if PREAMBLE_LEN = 0) -> HDR (14 bits) -> TA (2 bits) -> DATA (16 bits) -> DONE -> IDLE.
- Write / address frames:
  - mdio_oe = 1 for all N periods.
  - TA driven as 1,0.
  - DATA = latched wr_data.
- Read frames:
  - mdio_oe = 1 through HDR.
  - mdio_oe = 0 from the first TA period through the end of DATA.
  - Second TA sample must be 0; otherwise rd_err = 1.
  - 16 DATA samples are shifted in MSB first.
- DONE is one cycle, at E + 1 + 2*CLK_DIV*N:
  - done = 1, busy = 0, mdc = 0, mdio_oe = 0.
  - For reads, rd_data loads the shifted value and rd_err is updated.
  - For writes, rd_data is held and rd_err = 0.
- Back-to-back: a start in the cycle after DONE (FSM in IDLE) is accepted. MDC stays low for at least 1 cycle between frames.
- Idle: mdc is held at 0 and mdio_oe at 0 whenever the FSM is not in a frame.

Test Plan:
- C22 write, CLK_DIV=2, PREAMBLE_LEN=32, phy=5'h03, reg=5'h00, wr_data=16'h1234, start at E -> 32 ones then 01 01 00011 00000 10 0x1234 sampled at MDC rises; mdio_oe = 1 throughout; done at E+257; rd_err = 0.
- C22 read, op=10, PHY model drives TA = z,0 and data 16'hBEEF on MDC falls -> mdio_oe drops at TA start; done with rd_data = 16'hBEEF, rd_err = 0.
- C22 read, no PHY (mdio_in held 1) -> rd_data = 16'hFFFF, rd_err = 1.
- C45, mode=1, op=00 addr 16'h0800 then op=11 read, DEVAD=5'h01 -> ST = 00 on both; second frame accepted the cycle after first done; read returns the PHY value.
- start pulsed every cycle during a frame, and PREAMBLE_LEN=0 build -> only one frame sent; frame begins with ST; done at E+1+2*CLK_DIV*32.
- rst asserted mid-DATA of a read -> next cycle mdc = 0, mdio_oe = 0, busy = 0, rd_data = 0, no done; a new start afterwards completes normally.
